// File: rtl/weight_bank_ctrl.sv
// Multi-bank weight memory controller: the write side fills banks in rotation while the
// read side replays the oldest full bank for a configurable number of passes.
module weight_bank_ctrl #(
  parameter int unsigned WR_ADDR_DEPTH = 10,
  parameter int unsigned RD_ADDR_DEPTH = 8,
  parameter int unsigned BANK_NUM      = 2,
  parameter int unsigned BANK_W        = 1,
  parameter int unsigned REP_W         = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic [WR_ADDR_DEPTH:0]   cfg_wr_len,
  input  logic [RD_ADDR_DEPTH:0]   cfg_rd_len,
  input  logic [REP_W-1:0]         cfg_rd_rep,
  input  logic                     wt_valid,
  output logic                     wt_ready,
  output logic                     wr_en,
  output logic [BANK_W-1:0]        wr_bank,
  output logic [WR_ADDR_DEPTH-1:0] addr_wr,
  input  logic                     rd_start,
  output logic                     rd_busy,
  output logic                     rd_en,
  output logic [BANK_W-1:0]        rd_bank,
  output logic [RD_ADDR_DEPTH-1:0] addr_rd,
  output logic                     rd_last,
  output logic                     state_rst,
  output logic [BANK_W:0]          bank_cnt
);

  localparam logic [BANK_W-1:0]        LastBank = BANK_W'(BANK_NUM - 1);
  localparam logic [BANK_W-1:0]        BankOne  = BANK_W'(1);
  localparam logic [BANK_W:0]          BankNum  = (BANK_W + 1)'(BANK_NUM);
  localparam logic [BANK_W:0]          CntOne   = (BANK_W + 1)'(1);
  localparam logic [WR_ADDR_DEPTH:0]   WrOne    = (WR_ADDR_DEPTH + 1)'(1);
  localparam logic [WR_ADDR_DEPTH-1:0] WrInc    = WR_ADDR_DEPTH'(1);
  localparam logic [RD_ADDR_DEPTH:0]   RdOne    = (RD_ADDR_DEPTH + 1)'(1);
  localparam logic [RD_ADDR_DEPTH-1:0] RdInc    = RD_ADDR_DEPTH'(1);
  localparam logic [REP_W-1:0]         RepOne   = REP_W'(1);

  typedef enum logic {StIdle, StRead} rd_state_e;

  rd_state_e                state_q, state_d;
  logic [BANK_W-1:0]        wb_q, wb_d, rb_q, rb_d, rd_bank_q, rd_bank_d;
  logic [BANK_W:0]          bank_cnt_q, bank_cnt_d;
  logic [WR_ADDR_DEPTH-1:0] addr_wr_q, addr_wr_d;
  logic [WR_ADDR_DEPTH:0]   wr_len_q, wr_len_d;
  logic [RD_ADDR_DEPTH-1:0] addr_rd_q, addr_rd_d;
  logic [RD_ADDR_DEPTH:0]   rd_len_q, rd_len_d;
  logic [REP_W-1:0]         rd_rep_q, rd_rep_d, pass_q, pass_d;
  logic                     rd_last_q, rd_last_d, state_rst_q, state_rst_d;

  logic [WR_ADDR_DEPTH:0]   wr_len_norm, wr_len_cur;
  logic [RD_ADDR_DEPTH:0]   rd_len_norm;
  logic [REP_W-1:0]         rd_rep_norm;
  logic                     wr_done, release_bank;

  function automatic logic [BANK_W-1:0] bank_inc(input logic [BANK_W-1:0] b);
    return (b == LastBank) ? '0 : b + BankOne;
  endfunction

  assign wt_ready  = bank_cnt_q < BankNum;
  assign wr_en     = wt_valid & wt_ready;
  assign wr_bank   = wb_q;
  assign addr_wr   = addr_wr_q;
  assign rd_busy   = (state_q == StRead);
  assign rd_en     = (state_q == StRead);
  assign rd_bank   = rd_bank_q;
  assign addr_rd   = addr_rd_q;
  assign rd_last   = rd_last_q;
  assign state_rst = state_rst_q;
  assign bank_cnt  = bank_cnt_q;

  assign wr_len_norm = (cfg_wr_len == '0) ? WrOne : cfg_wr_len;
  assign rd_len_norm = (cfg_rd_len == '0) ? RdOne : cfg_rd_len;
  assign rd_rep_norm = (cfg_rd_rep == '0) ? RepOne : cfg_rd_rep;
  // Length is latched on the first beat of a bank; that beat uses the live value.
  assign wr_len_cur  = (addr_wr_q == '0) ? wr_len_norm : wr_len_q;
  assign wr_done     = wr_en && ({1'b0, addr_wr_q} == wr_len_cur - WrOne);

  always_comb begin
    state_d      = state_q;
    wb_d         = wb_q;
    rb_d         = rb_q;
    rd_bank_d    = rd_bank_q;
    bank_cnt_d   = bank_cnt_q;
    addr_wr_d    = addr_wr_q;
    wr_len_d     = wr_len_q;
    addr_rd_d    = addr_rd_q;
    rd_len_d     = rd_len_q;
    rd_rep_d     = rd_rep_q;
    pass_d       = pass_q;
    rd_last_d    = 1'b0;
    release_bank = 1'b0;

    if (wr_en) begin
      if (addr_wr_q == '0) wr_len_d = wr_len_norm;
      if (wr_done) begin
        addr_wr_d = '0;
        wb_d      = bank_inc(wb_q);
      end else begin
        addr_wr_d = addr_wr_q + WrInc;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (rd_start && (bank_cnt_q != '0)) begin
          state_d   = StRead;
          rd_len_d  = rd_len_norm;
          rd_rep_d  = rd_rep_norm;
          rd_bank_d = rb_q;
          addr_rd_d = '0;
          pass_d    = '0;
          rd_last_d = (rd_len_norm == RdOne) && (rd_rep_norm == RepOne);
        end
      end
      StRead: begin
        if (rd_last_q) begin
          state_d      = StIdle;
          release_bank = 1'b1;
          rb_d         = bank_inc(rb_q);
          addr_rd_d    = '0;
          pass_d       = '0;
        end else begin
          if ({1'b0, addr_rd_q} == rd_len_q - RdOne) begin
            addr_rd_d = '0;
            pass_d    = pass_q + RepOne;
          end else begin
            addr_rd_d = addr_rd_q + RdInc;
          end
          // Registered rd_last: flag the upcoming address if it ends the final pass.
          rd_last_d = ({1'b0, addr_rd_d} == rd_len_q - RdOne) && (pass_d == rd_rep_q - RepOne);
        end
      end
      default: state_d = StIdle;
    endcase

    case ({wr_done, release_bank})
      2'b10:   bank_cnt_d = bank_cnt_q + CntOne;
      2'b01:   bank_cnt_d = bank_cnt_q - CntOne;
      default: bank_cnt_d = bank_cnt_q;
    endcase

    state_rst_d = release_bank;

    if (flush) begin
      state_d     = StIdle;
      wb_d        = '0;
      rb_d        = '0;
      rd_bank_d   = '0;
      bank_cnt_d  = '0;
      addr_wr_d   = '0;
      wr_len_d    = '0;
      addr_rd_d   = '0;
      rd_len_d    = '0;
      rd_rep_d    = '0;
      pass_d      = '0;
      rd_last_d   = 1'b0;
      state_rst_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      wb_q        <= '0;
      rb_q        <= '0;
      rd_bank_q   <= '0;
      bank_cnt_q  <= '0;
      addr_wr_q   <= '0;
      wr_len_q    <= '0;
      addr_rd_q   <= '0;
      rd_len_q    <= '0;
      rd_rep_q    <= '0;
      pass_q      <= '0;
      rd_last_q   <= 1'b0;
      state_rst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      rd_bank_q   <= rd_bank_d;
      bank_cnt_q  <= bank_cnt_d;
      addr_wr_q   <= addr_wr_d;
      wr_len_q    <= wr_len_d;
      addr_rd_q   <= addr_rd_d;
      rd_len_q    <= rd_len_d;
      rd_rep_q    <= rd_rep_d;
      pass_q      <= pass_d;
      rd_last_q   <= rd_last_d;
      state_rst_q <= state_rst_d;
    end
  end

endmodule

// File: tb/tb_weight_bank_ctrl.sv
// Self-checking bench for weight_bank_ctrl: directed scenarios plus a randomized run
// compared against a queue-based bank/read-schedule model.
module tb_weight_bank_ctrl;

  localparam int BN = 2;
  localparam logic [18:0] IDLE_ST = 19'h40000;  // only wt_ready set

  logic       clk = 1'b0, rstn = 1'b0, flush = 1'b0;
  logic [10:0] cfg_wr_len = '0;
  logic [8:0]  cfg_rd_len = '0;
  logic [7:0]  cfg_rd_rep = '0;
  logic        wt_valid = 1'b0, rd_start = 1'b0;
  logic        wt_ready, wr_en, rd_busy, rd_en, rd_last, state_rst;
  logic [0:0]  wr_bank, rd_bank;
  logic [9:0]  addr_wr;
  logic [7:0]  addr_rd;
  logic [1:0]  bank_cnt;

  int n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  weight_bank_ctrl dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .cfg_wr_len(cfg_wr_len), .cfg_rd_len(cfg_rd_len), .cfg_rd_rep(cfg_rd_rep),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wr_en(wr_en), .wr_bank(wr_bank),
    .addr_wr(addr_wr), .rd_start(rd_start), .rd_busy(rd_busy), .rd_en(rd_en),
    .rd_bank(rd_bank), .addr_rd(addr_rd), .rd_last(rd_last), .state_rst(state_rst),
    .bank_cnt(bank_cnt)
  );

  // Reference model: bank counters plus a queue holding the remaining read schedule.
  int m_wb, m_rb, m_cnt, m_waddr, m_wlen, m_rd_bank;
  bit m_srst;
  int rdq[$];

  always @(posedge clk or negedge rstn) begin
    int l, r;
    bit done, rel;
    if (!rstn || flush) begin
      m_wb = 0; m_rb = 0; m_cnt = 0; m_waddr = 0; m_wlen = 1; m_rd_bank = 0; m_srst = 0;
      rdq.delete();
    end else begin
      done = 0; rel = 0; m_srst = 0;
      if (rdq.size() > 0) begin
        void'(rdq.pop_front());
        if (rdq.size() == 0) begin
          rel = 1; m_srst = 1; m_rb = (m_rb + 1) % BN;
        end
      end else if (rd_start && m_cnt > 0) begin
        l = (cfg_rd_len == 0) ? 1 : int'(cfg_rd_len);
        r = (cfg_rd_rep == 0) ? 1 : int'(cfg_rd_rep);
        m_rd_bank = m_rb;
        for (int p = 0; p < r; p++)
          for (int a = 0; a < l; a++)
            rdq.push_back(a * 2 + ((p == r - 1 && a == l - 1) ? 1 : 0));
      end
      if (wt_valid && m_cnt < BN) begin
        if (m_waddr == 0) m_wlen = (cfg_wr_len == 0) ? 1 : int'(cfg_wr_len);
        if (m_waddr == m_wlen - 1) begin
          m_waddr = 0; m_wb = (m_wb + 1) % BN; done = 1;
        end else begin
          m_waddr++;
        end
      end
      m_cnt = m_cnt + int'(done) - int'(rel);
    end
  end

  task automatic drive(input logic v, input logic s, input logic f);
    @(negedge clk);
    wt_valid = v; rd_start = s; flush = f;
    #1;
  endtask

  function automatic logic [18:0] status();
    return {wt_ready, wr_en, wr_bank, addr_wr, rd_busy, rd_en, rd_last, state_rst, bank_cnt};
  endfunction

  task automatic set_cfg(input int wl, input int rl, input int rr);
    cfg_wr_len = 11'(wl); cfg_rd_len = 9'(rl); cfg_rd_rep = 8'(rr);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(0, 0, 0);
    n_checks++;
    if (status() !== IDLE_ST) begin
      n_errors++; $display("FAIL reset_in: got %h want %h", status(), IDLE_ST);
    end
    @(negedge clk); rstn = 1'b1;
    drive(0, 0, 0);
    n_checks++;
    if (status() !== IDLE_ST) begin
      n_errors++; $display("FAIL reset_out: got %h want %h", status(), IDLE_ST);
    end
  endtask

  task automatic test_basic();
    logic [31:0] got, exp;
    set_cfg(4, 3, 2);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0);
      got = 32'({wr_en, wr_bank, addr_wr, bank_cnt}); exp = 32'({1'b1, 1'b0, 10'(i), 2'd0});
      n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL basic_wr%0d: got %h want %h", i, got, exp); end
    end
    drive(0, 1, 0);
    n_checks++;
    if (bank_cnt !== 2'd1) begin n_errors++; $display("FAIL basic_cnt1: got %0d want 1", bank_cnt); end
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0);
      got = 32'({rd_busy, rd_en, addr_rd, rd_last, rd_bank, state_rst});
      exp = 32'({1'b1, 1'b1, 8'(k % 3), k == 5, 1'b0, 1'b0});
      n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL basic_rd%0d: got %h want %h", k, got, exp); end
    end
    drive(0, 0, 0);
    got = 32'({rd_busy, rd_en, rd_last, state_rst, bank_cnt}); exp = 32'({4'b0001, 2'd0});
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL basic_release: got %h want %h", got, exp); end
    drive(0, 0, 0);
    n_checks++;
    if (state_rst !== 1'b0) begin n_errors++; $display("FAIL basic_pulse: got %b want 0", state_rst); end
  endtask

  task automatic test_backpressure();
    logic [31:0] got, exp;
    set_cfg(4, 3, 2);
    drive(0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0);
      if (i < 8) begin
        got = 32'({wt_ready, wr_en, wr_bank, addr_wr}); exp = 32'({2'b11, 1'(i / 4), 10'(i % 4)});
      end else begin
        got = 32'({wt_ready, wr_en, bank_cnt}); exp = 32'({2'b00, 2'd2});
      end
      n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL bp_beat%0d: got %h want %h", i, got, exp); end
    end
    drive(1, 1, 0);
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 0);
      got = 32'({rd_en, addr_rd, rd_bank, wt_ready, wr_en}); exp = 32'({1'b1, 8'(k % 3), 3'b000});
      n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL bp_rd%0d: got %h want %h", k, got, exp); end
    end
    drive(1, 0, 0);
    got = 32'({state_rst, rd_busy, bank_cnt, wt_ready, wr_en, wr_bank, addr_wr});
    exp = 32'({2'b10, 2'd1, 3'b110, 10'd0});
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL bp_resume: got %h want %h", got, exp); end
  endtask

  // Continues from test_backpressure: bank 1 full, bank 0 at address 1.
  task automatic test_simultaneous();
    logic [31:0] got, exp;
    drive(0, 1, 0);
    got = 32'({rd_busy, bank_cnt}); exp = 32'({1'b0, 2'd1});
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL sim_start: got %h want %h", got, exp); end
    for (int k = 1; k <= 6; k++) begin
      drive(k >= 4, 0, 0);
      got = 32'({rd_en, rd_bank, addr_rd, rd_last, wr_en, addr_wr, bank_cnt});
      exp = 32'({2'b11, 8'((k - 1) % 3), k == 6, k >= 4, 10'((k >= 4) ? k - 3 : 1), 2'd1});
      n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL sim_cyc%0d: got %h want %h", k, got, exp); end
    end
    drive(0, 1, 0);
    got = 32'({state_rst, bank_cnt, wr_bank, rd_busy}); exp = 32'({1'b1, 2'd1, 2'b10});
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL sim_both: got %h want %h", got, exp); end
    drive(0, 0, 0);
    got = 32'({rd_busy, rd_bank, addr_rd}); exp = 32'({2'b10, 8'd0});
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL sim_next_bank: got %h want %h", got, exp); end
    drive(0, 0, 1);
  endtask

  task automatic test_ignored();
    logic [31:0] got, exp;
    set_cfg(4, 3, 2);
    drive(0, 0, 1);
    drive(0, 1, 0);
    drive(0, 0, 0);
    got = 32'({rd_busy, rd_en, state_rst, bank_cnt, addr_rd}); exp = 0;
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL ign_empty: got %h want %h", got, exp); end
    for (int i = 0; i < 4; i++) drive(1, 0, 0);
    drive(0, 1, 0);
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 0);
      got = 32'({rd_en, addr_rd, rd_last, bank_cnt}); exp = 32'({1'b1, 8'(k % 3), k == 5, 2'd1});
      n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL ign_busy%0d: got %h want %h", k, got, exp); end
    end
    drive(0, 1, 0);
    got = 32'({state_rst, rd_busy, bank_cnt}); exp = 32'({2'b10, 2'd0});
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL ign_release: got %h want %h", got, exp); end
    drive(0, 0, 0);
    got = 32'({rd_busy, state_rst, bank_cnt}); exp = 0;
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL ign_after: got %h want %h", got, exp); end
  endtask

  task automatic test_zero_cfg();
    logic [31:0] got, exp;
    drive(0, 0, 1);
    set_cfg(0, 0, 0);
    drive(1, 0, 0);
    got = 32'({wr_en, wr_bank, addr_wr}); exp = 32'({2'b10, 10'd0});
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL zero_wr: got %h want %h", got, exp); end
    drive(0, 1, 0);
    got = 32'({bank_cnt, wr_bank}); exp = 32'({2'd1, 1'b1});
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL zero_full: got %h want %h", got, exp); end
    drive(0, 0, 0);
    got = 32'({rd_en, addr_rd, rd_last, rd_bank}); exp = 32'({1'b1, 8'd0, 2'b10});
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL zero_rd: got %h want %h", got, exp); end
    drive(0, 0, 0);
    got = 32'({state_rst, rd_busy, rd_last, bank_cnt}); exp = 32'({3'b100, 2'd0});
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL zero_release: got %h want %h", got, exp); end
  endtask

  task automatic test_abort(input bit use_reset);
    logic [31:0] got, exp;
    drive(0, 0, 1);
    set_cfg(4, 3, 2);
    for (int i = 0; i < 6; i++) drive(1, 0, 0);
    drive(0, 1, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    if (use_reset) begin
      @(negedge clk); #2 rstn = 1'b0; #1;
      n_checks++;
      if (status() !== IDLE_ST) begin
        n_errors++; $display("FAIL abort_rst_async: got %h want %h", status(), IDLE_ST);
      end
      @(negedge clk); rstn = 1'b1;
    end else begin
      drive(0, 0, 1);
    end
    drive(0, 0, 0);
    n_checks++;
    if (status() !== IDLE_ST) begin
      n_errors++; $display("FAIL abort_idle%0d: got %h want %h", use_reset, status(), IDLE_ST);
    end
    drive(1, 0, 0);
    got = 32'({wr_en, wr_bank, addr_wr}); exp = 32'({2'b10, 10'd0});
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL abort_refill%0d: got %h want %h", use_reset, got, exp); end
  endtask

  task automatic test_random();
    logic [31:0] got, exp;
    logic v, s, f;
    bit busy;
    drive(0, 0, 1);
    for (int c = 0; c < 800; c++) begin
      set_cfg($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 3));
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 99) == 0);
      drive(v, s, f);
      busy = (rdq.size() > 0);
      got = 32'({status(), busy ? {rd_bank, addr_rd} : 9'd0});
      exp = 32'({m_cnt < BN, v && (m_cnt < BN), 1'(m_wb), 10'(m_waddr), busy, busy,
                 busy && ((rdq[0] & 1) != 0), m_srst, 2'(m_cnt),
                 busy ? {1'(m_rd_bank), 8'(rdq[0] >> 1)} : 9'd0});
      n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL rand_c%0d: got %h want %h", c, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_simultaneous();
    test_ignored();
    test_zero_cfg();
    test_abort(1'b0);
    test_abort(1'b1);
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/weight_bank_ctrl.md
# weight_bank_ctrl

Multi-bank (ping-pong by default) address and handshake controller for the weight memory in the DRM unit. Incoming weight words are written into one bank while the compute array reads a previously filled bank, optionally re-reading it several times (one pass per output tile). Independent write-side and read-side counters replace the single-bank, state-driven address generation. A bank is released, and `state_rst` pulsed, once its final read pass completes.

## Interface
Parameters:
- `WR_ADDR_DEPTH`, 10, write address width; one bank holds up to 2^WR_ADDR_DEPTH write words.
- `RD_ADDR_DEPTH`, 8, read address width (wider read words).
- `BANK_NUM`, 2, number of weight banks; must be ≥2.
- `BANK_W`, 1, bank index width; must satisfy 2^BANK_W ≥ BANK_NUM.
- `REP_W`, 8, width of the read-pass repeat count.

Ports:
- `clk`, in, 1: clock. Single clock domain.
- `rstn`, in, 1: asynchronous, active-low reset.
- `flush`, in, 1: synchronous clear of all banks and counters.
- `cfg_wr_len`, in, WR_ADDR_DEPTH+1: write words per bank, 1..2^WR_ADDR_DEPTH. A value of 0 is treated as 1.
- `cfg_rd_len`, in, RD_ADDR_DEPTH+1: read words per pass, 1..2^RD_ADDR_DEPTH. A value of 0 is treated as 1.
- `cfg_rd_rep`, in, REP_W: passes per bank. A value of 0 is treated as 1.
- `wt_valid`, in, 1: weight word available.
- `wt_ready`, out, 1: write side can accept.
- `wr_en`, out, 1: equals `wt_valid & wt_ready`.
- `wr_bank`, out, BANK_W: bank currently being filled.
- `addr_wr`, out, WR_ADDR_DEPTH: address of the current write word.
- `rd_start`, in, 1: request one read sequence on the oldest full bank.
- `rd_busy`, out, 1: read sequence in progress.
- `rd_en`, out, 1: read strobe.
- `rd_bank`, out, BANK_W: bank being read.
- `addr_rd`, out, RD_ADDR_DEPTH: read address.
- `rd_last`, out, 1: marks the final address of the final pass.
- `state_rst`, out, 1: one-cycle pulse when a bank is released.
- `bank_cnt`, out, BANK_W+1: number of full, unreleased banks.

## Operation
- **Bank tracking:** write pointer `wb`, read pointer `rb`, and full count `bank_cnt`. Both pointers wrap from BANK_NUM-1 to 0.
- **`wt_ready`:** `bank_cnt < BANK_NUM`. This is combinational from registers only and has no dependence on `wt_valid`.
- **Write side:**
  - Each accepted beat writes `addr_wr`, then `addr_wr` increments.
  - `cfg_wr_len` is sampled on the first beat of each bank.
  - On the beat with `addr_wr == len-1`: `addr_wr` returns to 0, `wb` advances, and `bank_cnt` increments.
- **Read side:**
  - Two states: IDLE and READ.
  - IDLE→READ on `rd_start & (bank_cnt>0)`. On that transition, `cfg_rd_len` and `cfg_rd_rep` are sampled and `rd_bank` is set to `rb`.
  - `rd_start` is ignored while READ is active or while `bank_cnt==0`.
  - In READ, `rd_en` is high every cycle and `addr_rd` counts 0..len-1. At the end of each pass it wraps to 0 and the pass counter increments.
  - After the final address of the final pass: READ→IDLE, `rb` advances, `bank_cnt` decrements, and `state_rst` pulses.
- **Simultaneous events:**
  - If a bank completes filling in the same cycle another is released, `bank_cnt` is unchanged and both pointers advance.
  - No read/write hazard can occur: `rb==wb` with a fill in progress implies `bank_cnt==0`, so no read can be active on that bank.
- **`flush`:** same effect as reset, but synchronous. It aborts any partial fill and any active read.

## Timing
- **Reset / flush values:**
  - All counters, pointers and `bank_cnt` = 0.
  - `rd_busy`, `rd_en`, `rd_last`, `state_rst`, `wr_en` = 0.
  - `wt_ready` = 1.
- **Write path:**
  - `wr_en`, `addr_wr` and `wr_bank` are valid in the acceptance cycle; the increment takes effect next cycle.
  - `bank_cnt` reflects a completed bank one cycle after its final write beat.
- **Read latency:**
  - `rd_start` accepted at cycle t → `rd_busy`, `rd_en` = 1 with `addr_rd`=0 at t+1.
  - The last read is at t+L·R.
  - At t+L·R+1: `rd_busy`=0, `state_rst`=1 for one cycle, `bank_cnt` decremented.
- **`rd_last`:** high only in cycle t+L·R.
- **Back-to-back reads:** a new `rd_start` is accepted at t+L·R+1 at the earliest.
- **Read outputs:** all registered.

## Test plan
- **Basic fill and read:** BANK_NUM=2, wr_len=4, rd_len=3, rep=2. Four beats, then `rd_start` → `bank_cnt` goes 0→1→0; `addr_rd` sequence 0,1,2,0,1,2; `rd_last` on the 6th read; `state_rst` one cycle later.
- **Backpressure:** stream 3 full banks of wr_len=4 without reading → `wt_ready` falls after beat 8 with `bank_cnt`=2. One read release → `wt_ready` returns and the 9th beat writes `wr_bank`=0, `addr_wr`=0.
- **Simultaneous fill-complete and release:** `bank_cnt` stays 1 while `rd_bank` and `wr_bank` both advance.
- **Ignored starts:** `rd_start` with `bank_cnt`=0, or while `rd_busy`=1 → no change to state, addresses or counts.
- **Zero config:** `cfg_wr_len`=0, `cfg_rd_len`=0, `cfg_rd_rep`=0 → a bank fills after 1 beat and a single read with `rd_last` set.
- **Flush and async reset mid-operation:** assert each during a partial fill and an active read → all outputs take their reset values and `wt_ready`=1. The next fill starts at bank 0, address 0.
